// File: rtl/bnn_classifier_core_if.sv
// ---------------------------------------------------------------------------
// bnn_classifier_core_if
// Feature-in / result-out handshake bundle for bnn_classifier_core.
//   in_valid  / in_ready  / in_bits   : binarised feature vector (producer -> core)
//   out_valid / out_ready             : result handshake (core -> consumer)
//   out_class                         : winning class index, CLS_W bits
//   out_score                         : winning class score, signed, SW bits
// Modports:
//   master : feature producer / result consumer side
//   slave  : the classifier core
// ---------------------------------------------------------------------------
interface bnn_classifier_core_if #(
  parameter int N_IN  = 8,
  parameter int N_HID = 8,
  parameter int N_OUT = 2
) ();
  localparam int CLS_W = $clog2(N_OUT);
  localparam int SW    = $clog2(N_HID + 1) + 2;

  logic                    in_valid;
  logic                    in_ready;
  logic [N_IN-1:0]         in_bits;
  logic                    out_valid;
  logic                    out_ready;
  logic [CLS_W-1:0]        out_class;
  logic signed [SW-1:0]    out_score;

  modport master (
    output in_valid, in_bits, out_ready,
    input  in_ready, out_valid, out_class, out_score
  );

  modport slave (
    input  in_valid, in_bits, out_ready,
    output in_ready, out_valid, out_class, out_score
  );
endinterface

// File: rtl/bnn_classifier_core.sv
// ---------------------------------------------------------------------------
// bnn_classifier_core
// Binary neural network classifier: one hidden layer and one output layer,
// evaluated sequentially one neuron per clock, bipolar (XNOR-popcount) scores,
// argmax over the output classes with ties resolved to the lowest index.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   ena         : global enable, low freezes all state
//   bus         : bnn_classifier_core_if.slave (feature in / result out)
//   hidden_act  : latched hidden activations
//   busy        : high whenever the core is not idle
//   wl_valid    : weight-load shift strobe (only with BNN_WEIGHT_LOAD_EN)
//   wl_bit      : weight-load serial data, MSB of the image first
//
// Build option:
//   BNN_WEIGHT_LOAD_EN : when defined, the weight image {BIAS, W_HO, W_IH}
//   lives in a shift register loadable while idle; otherwise the *_INIT
//   parameters are used as constants and wl_valid/wl_bit are ignored.
// ---------------------------------------------------------------------------
module bnn_classifier_core #(
  parameter int N_IN   = 8,
  parameter int N_HID  = 8,
  parameter int N_OUT  = 2,
  parameter int BIAS_W = 4,
  parameter logic [N_HID*N_IN-1:0]   W_IH_INIT = '1,
  // class 0 all zeros, every other class all ones
  parameter logic [N_OUT*N_HID-1:0]  W_HO_INIT = {{((N_OUT-1)*N_HID){1'b1}}, {N_HID{1'b0}}},
  parameter logic [N_HID*BIAS_W-1:0] BIAS_INIT = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  bnn_classifier_core_if.slave bus,
  output logic [N_HID-1:0]     hidden_act,
  output logic                 busy,
  input  logic                 wl_valid,
  input  logic                 wl_bit
);
  localparam int CLS_W   = $clog2(N_OUT);
  localparam int SW      = $clog2(N_HID + 1) + 2;
  localparam int HO_LSB  = N_HID * N_IN;
  localparam int B_LSB   = HO_LSB + N_OUT * N_HID;
  localparam int WB      = B_LSB + N_HID * BIAS_W;
  // one counter serves as h in HID and o in OUT; OUT runs one extra step
  // (o == N_OUT) that commits the best class to the outputs
  localparam int CNT_MAX = (N_HID > N_OUT + 1) ? N_HID : N_OUT + 1;
  localparam int CW      = $clog2(CNT_MAX);

  typedef enum logic [1:0] {IDLE, HID, OUT, DONE} state_t;

  state_t               state_reg, state_next;
  logic [CW-1:0]        cnt_reg;
  logic [N_IN-1:0]      x_reg;
  logic [N_HID-1:0]     hid_reg, hid_next;
  logic signed [SW-1:0] best_reg;
  logic [CLS_W-1:0]     best_idx_reg;
  logic [CLS_W-1:0]     cls_reg;
  logic signed [SW-1:0] score_reg;

  logic [WB-1:0]        img;

`ifdef BNN_WEIGHT_LOAD_EN
  logic [WB-1:0] img_reg;

  // Shifting only while idle keeps the image constant during a computation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      img_reg <= {BIAS_INIT, W_HO_INIT, W_IH_INIT};
    end else if (ena && wl_valid && state_reg == IDLE) begin
      img_reg <= {img_reg[WB-2:0], wl_bit};
    end
  end

  assign img = img_reg;
`else
  logic unused_wl;
  assign unused_wl = wl_valid ^ wl_bit;
  assign img = {BIAS_INIT, W_HO_INIT, W_IH_INIT};
`endif

  // Unpack the flat image into per-neuron weights and biases.
  logic [N_IN-1:0]          w_ih_arr [N_HID];
  logic signed [BIAS_W-1:0] bias_arr [N_HID];
  logic [N_HID-1:0]         w_ho_arr [N_OUT];

  genvar gi;
  generate
    for (gi = 0; gi < N_HID; gi++) begin : g_hid
      assign w_ih_arr[gi] = img[gi*N_IN +: N_IN];
      assign bias_arr[gi] = img[B_LSB + gi*BIAS_W +: BIAS_W];
    end
    for (gi = 0; gi < N_OUT; gi++) begin : g_out
      assign w_ho_arr[gi] = img[HO_LSB + gi*N_HID +: N_HID];
    end
  endgenerate

  // Datapath for the neuron selected by cnt_reg.
  logic [N_IN-1:0]          w_h;
  logic signed [BIAS_W-1:0] b_h;
  logic [N_HID-1:0]         w_o;
  int                       s_h_int;
  logic                     act;
  logic signed [SW-1:0]     s_o;

  always_comb begin
    w_h = '0;
    b_h = '0;
    w_o = '0;
    for (int i = 0; i < N_HID; i++) begin
      if (cnt_reg == CW'(i)) begin
        w_h = w_ih_arr[i];
        b_h = bias_arr[i];
      end
    end
    for (int i = 0; i < N_OUT; i++) begin
      if (cnt_reg == CW'(i)) w_o = w_ho_arr[i];
    end
    // hidden score is formed at full integer width so bias cannot wrap it
    s_h_int = 2 * $countones(~(x_reg ^ w_h)) - N_IN + int'(b_h);
    act     = (s_h_int >= 0);
    s_o     = SW'(2 * $countones(~(hid_reg ^ w_o)) - N_HID);
  end

  always_comb begin
    hid_next = hid_reg;
    for (int i = 0; i < N_HID; i++) begin
      if (cnt_reg == CW'(i)) hid_next[i] = act;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (ena && bus.in_valid)                 state_next = HID;
      HID:     if (ena && cnt_reg == CW'(N_HID - 1))    state_next = OUT;
      OUT:     if (ena && cnt_reg == CW'(N_OUT))        state_next = DONE;
      DONE:    if (ena && bus.out_ready)                state_next = IDLE;
      default:                                          state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      x_reg        <= '0;
      hid_reg      <= '0;
      best_reg     <= '0;
      best_idx_reg <= '0;
      cls_reg      <= '0;
      score_reg    <= '0;
    end else if (ena) begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            x_reg   <= bus.in_bits;
            cnt_reg <= '0;
          end
        end
        HID: begin
          hid_reg <= hid_next;
          cnt_reg <= (cnt_reg == CW'(N_HID - 1)) ? '0 : cnt_reg + 1'b1;
        end
        OUT: begin
          if (cnt_reg == CW'(N_OUT)) begin
            cls_reg   <= best_idx_reg;
            score_reg <= best_reg;
          end else if (cnt_reg == '0 || s_o > best_reg) begin
            // strict compare: an equal later score never displaces the leader
            best_reg     <= s_o;
            best_idx_reg <= CLS_W'(cnt_reg);
          end
          cnt_reg <= cnt_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = ena && (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.out_class = cls_reg;
  assign bus.out_score = score_reg;
  assign hidden_act    = hid_reg;
  assign busy          = (state_reg != IDLE);
endmodule

// File: tb/tb_bnn_classifier_core.sv
// ---------------------------------------------------------------------------
// tb_bnn_classifier_core
// Directed vectors with hand-computed results for bnn_classifier_core.
// dut uses the default weights; dut_tie uses equal output weights (0xF0)
// for both classes to exercise the lowest-index tie break.
// ---------------------------------------------------------------------------
module tb_bnn_classifier_core;
  localparam int WB = 64 + 16 + 32;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] hidden_act, hidden_act2;
  logic       busy, busy2;
  logic       wl_valid, wl_bit;

  int n_tests = 0;
  int n_fail  = 0;

  bnn_classifier_core_if #(.N_IN(8), .N_HID(8), .N_OUT(2)) bus ();
  bnn_classifier_core_if #(.N_IN(8), .N_HID(8), .N_OUT(2)) bus2 ();

  bnn_classifier_core dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .bus        (bus),
    .hidden_act (hidden_act),
    .busy       (busy),
    .wl_valid   (wl_valid),
    .wl_bit     (wl_bit)
  );

  bnn_classifier_core #(.W_HO_INIT(16'hF0F0)) dut_tie (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .bus        (bus2),
    .hidden_act (hidden_act2),
    .busy       (busy2),
    .wl_valid   (1'b0),
    .wl_bit     (1'b0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One full transaction on dut. hold > 0 keeps out_ready low that many
  // cycles in DONE; drop_at > 0 drops ena for 5 cycles at that cycle count;
  // wl_pulse strobes wl_valid/wl_bit=1 throughout the hidden pass.
  task automatic run_vec(input logic [7:0] bits, input logic [7:0] exp_hid,
                         input logic exp_cls, input logic [5:0] exp_score,
                         input int exp_lat, input int hold, input int drop_at,
                         input bit wl_pulse);
    int cyc;
    bit seen;
    bus.out_ready = (hold == 0);
    cyc = 0;
    while (!bus.in_ready && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_eq("in_ready_before", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_bits  = bits;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check_eq("busy", busy, 1);
    cyc  = 0;
    seen = 0;
    while (!seen && cyc < 60) begin
      if (drop_at != 0 && cyc == drop_at) begin
        ena = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        cyc += 5;
        check_eq("frozen_valid", bus.out_valid, 0);
        ena = 1'b1;
      end
      wl_valid = wl_pulse && (cyc < 8);
      wl_bit   = 1'b1;
      @(posedge clk); #1;
      cyc++;
      if (bus.out_valid) seen = 1;
    end
    wl_valid = 1'b0;
    wl_bit   = 1'b0;
    check_eq("latency", cyc, exp_lat);
    check_eq("hidden_act", hidden_act, exp_hid);
    check_eq("out_class", bus.out_class, exp_cls);
    check_eq("out_score", 64'(unsigned'(bus.out_score)), exp_score);
    check_eq("in_ready_done", bus.in_ready, 0);
    $display("[TB] vec in=%02h hid=%02h cls=%0d score=%0d lat=%0d",
             bits, hidden_act, bus.out_class, bus.out_score, cyc);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check_eq("hold_valid", bus.out_valid, 1);
      check_eq("hold_class", bus.out_class, exp_cls);
      check_eq("hold_score", 64'(unsigned'(bus.out_score)), exp_score);
      check_eq("hold_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("valid_after_hs", bus.out_valid, 0);
    check_eq("in_ready_after_hs", bus.in_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int vcount;
    logic [WB-1:0] img;

    rst_n = 1'b0;
    ena = 1'b0;
    wl_valid = 1'b0;
    wl_bit = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_bits = '0;
    bus.out_ready = 1'b1;
    bus2.in_valid = 1'b0;
    bus2.in_bits = '0;
    bus2.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rst_in_ready", bus.in_ready, 0);
    check_eq("rst_out_valid", bus.out_valid, 0);
    check_eq("rst_out_class", bus.out_class, 0);
    check_eq("rst_out_score", 64'(unsigned'(bus.out_score)), 0);
    check_eq("rst_hidden_act", hidden_act, 0);
    check_eq("rst_busy", busy, 0);
    ena = 1'b1;
    #1;
    check_eq("ena_in_ready", bus.in_ready, 1);

    run_vec(8'h00, 8'h00, 1'b0, 6'd8, 11, 0, 0, 1'b0);
    run_vec(8'h0F, 8'hFF, 1'b1, 6'd8, 11, 0, 0, 1'b0);
    run_vec(8'h07, 8'h00, 1'b0, 6'd8, 11, 20, 0, 1'b0);
    run_vec(8'h0F, 8'hFF, 1'b1, 6'd8, 16, 0, 3, 1'b0);

    // tie between the two classes on dut_tie
    cyc = 0;
    while (!bus2.in_ready && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    bus2.in_valid = 1'b1;
    bus2.in_bits  = 8'hFF;
    @(posedge clk); #1;
    bus2.in_valid = 1'b0;
    cyc = 0;
    while (!bus2.out_valid && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_eq("tie_latency", cyc, 11);
    check_eq("tie_hidden", hidden_act2, 8'hFF);
    check_eq("tie_class", bus2.out_class, 0);
    check_eq("tie_score", 64'(unsigned'(bus2.out_score)), 0);
    $display("[TB] tie in=ff hid=%02h cls=%0d score=%0d lat=%0d",
             hidden_act2, bus2.out_class, bus2.out_score, cyc);
    @(posedge clk); #1;
    check_eq("tie_valid_after_hs", bus2.out_valid, 0);

    // reset while the output layer is being evaluated
    bus.in_valid = 1'b1;
    bus.in_bits  = 8'h0F;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check_eq("midout_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_eq("abort_out_valid", bus.out_valid, 0);
    check_eq("abort_out_class", bus.out_class, 0);
    check_eq("abort_out_score", 64'(unsigned'(bus.out_score)), 0);
    check_eq("abort_hidden_act", hidden_act, 0);
    check_eq("abort_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    vcount = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid) vcount++;
    end
    check_eq("abort_no_valid", vcount, 0);
    check_eq("abort_in_ready", bus.in_ready, 1);
    $display("[TB] abort mid-OUT: out_valid pulses=%0d", vcount);

    // serial weight image: all hidden biases -1, weights unchanged
    img = {32'hFFFF_FFFF, 16'hFF00, 64'hFFFF_FFFF_FFFF_FFFF};
    for (int i = WB - 1; i >= 0; i--) begin
      wl_valid = 1'b1;
      wl_bit   = img[i];
      @(posedge clk); #1;
    end
    wl_valid = 1'b0;
    wl_bit   = 1'b0;
`ifdef BNN_WEIGHT_LOAD_EN
    run_vec(8'h0F, 8'h00, 1'b0, 6'd8, 11, 0, 0, 1'b0);
    run_vec(8'h0F, 8'h00, 1'b0, 6'd8, 11, 0, 0, 1'b1);
`else
    run_vec(8'h0F, 8'hFF, 1'b1, 6'd8, 11, 0, 0, 1'b0);
    run_vec(8'h0F, 8'hFF, 1'b1, 6'd8, 11, 0, 0, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
